// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the CPU/DMA block-RAM port arbiter: FSM encodings,
// requester ids and the saturating starvation-counter helper.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ISSUE = 2'b01;
  localparam logic [1:0] ST_RESP  = 2'b10;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU port, DMA port and RAM pins around the arbiter.
// Handshake: a requester raises req with addr/we/wdata and holds them all stable
// until it samples its one-cycle ack; req may drop in the ack cycle or later, and
// a req still high when the arbiter returns to idle is taken as a fresh request.
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          dma_req;
  logic [AW-1:0] dma_addr;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dma_req, dma_addr,
    output dma_ack, dma_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dma_req, dma_addr,
    input  dma_ack, dma_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner selection for the arbiter; kept separate so the
// priority policy can be exercised on its own.
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
  input  logic last_grant,
  input  logic starved,
  input  logic mode,        // 1 = CPU priority with starvation guard, 0 = round-robin
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = cpu_req | dma_req;
    grant_id    = REQ_CPU;
    if (cpu_req && dma_req) begin
      if (mode) grant_id = starved ? REQ_DMA : REQ_CPU;
      else      grant_id = (last_grant == REQ_CPU) ? REQ_DMA : REQ_CPU;
    end else if (dma_req) begin
      grant_id = REQ_DMA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU (read/write) and DMA (read-only) accesses onto one synchronous
// block RAM with a three-state IDLE -> ISSUE -> RESP sequence per access.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int CPU_PRIORITY = 1,
  parameter int MAX_WAIT     = 8
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  logic [1:0]    state;
  logic          lat_id;
  logic          lat_we;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          mem_we_q;
  logic          cpu_ack_q;
  logic          dma_ack_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] dma_rdata_q;
  logic          last_grant;
  logic [7:0]    starve_cnt;

  logic grant_valid;
  logic grant_id;
  logic starved;
  logic resp_read;

  assign starved = (starve_cnt >= 8'(MAX_WAIT));

  arb_pick u_pick (
    .cpu_req     (bus.cpu_req),
    .dma_req     (bus.dma_req),
    .last_grant  (last_grant),
    .starved     (starved),
    .mode        (CPU_PRIORITY != 0),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      lat_id      <= REQ_CPU;
      lat_we      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      last_grant  <= REQ_DMA;
      starve_cnt  <= 8'd0;
    end else begin
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            state    <= ST_ISSUE;
            lat_id   <= grant_id;
            lat_we   <= (grant_id == REQ_CPU) && bus.cpu_we;
            mem_we_q <= (grant_id == REQ_CPU) && bus.cpu_we;
            if (grant_id == REQ_DMA) begin
              mem_addr_q <= bus.dma_addr;
              starve_cnt <= 8'd0;
            end else begin
              mem_addr_q  <= bus.cpu_addr;
              mem_wdata_q <= bus.cpu_wdata;
              if (bus.dma_req) starve_cnt <= sat_inc8(starve_cnt);
            end
          end
        end
        ST_ISSUE: begin
          state     <= ST_RESP;
          mem_we_q  <= 1'b0;
          cpu_ack_q <= (lat_id == REQ_CPU);
          dma_ack_q <= (lat_id == REQ_DMA);
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          last_grant <= lat_id;
          // The ack-cycle value is forwarded below; this keeps it afterwards.
          if (!lat_we) begin
            if (lat_id == REQ_CPU) cpu_rdata_q <= bus.mem_rdata;
            else                   dma_rdata_q <= bus.mem_rdata;
          end
        end
        default: begin
          state    <= ST_IDLE;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  // RAM data only arrives during RESP, so the ack cycle sees it straight through.
  assign resp_read = (state == ST_RESP) && !lat_we;

  assign bus.cpu_rdata = (resp_read && lat_id == REQ_CPU) ? bus.mem_rdata : cpu_rdata_q;
  assign bus.dma_rdata = (resp_read && lat_id == REQ_DMA) ? bus.mem_rdata : dma_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign busy          = (state != ST_IDLE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin and a CPU-priority
// (MAX_WAIT=2) instance share one stimulus, each with its own RAM and scoreboard.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          cpu_req, cpu_we, dma_req;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus_rr ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus_pri ();

  logic       busy_rr, busy_pri;
  logic [1:0] st_rr, st_pri;

  mem_port_arbiter #(.AW(AW), .DW(DW), .CPU_PRIORITY(0), .MAX_WAIT(8)) u_rr (
    .clk(clk), .reset(reset), .bus(bus_rr.slave), .busy(busy_rr), .state_dbg(st_rr)
  );
  mem_port_arbiter #(.AW(AW), .DW(DW), .CPU_PRIORITY(1), .MAX_WAIT(2)) u_pri (
    .clk(clk), .reset(reset), .bus(bus_pri.slave), .busy(busy_pri), .state_dbg(st_pri)
  );

  assign bus_rr.cpu_req   = cpu_req;   assign bus_pri.cpu_req   = cpu_req;
  assign bus_rr.cpu_we    = cpu_we;    assign bus_pri.cpu_we    = cpu_we;
  assign bus_rr.cpu_addr  = cpu_addr;  assign bus_pri.cpu_addr  = cpu_addr;
  assign bus_rr.cpu_wdata = cpu_wdata; assign bus_pri.cpu_wdata = cpu_wdata;
  assign bus_rr.dma_req   = dma_req;   assign bus_pri.dma_req   = dma_req;
  assign bus_rr.dma_addr  = dma_addr;  assign bus_pri.dma_addr  = dma_addr;

  // ---------------- RAM models (1-cycle registered read) ----------------
  function automatic logic [DW-1:0] init_word(input logic [7:0] a);
    return (a == 8'h40) ? 16'h1234 : {a ^ 8'hA5, a};
  endfunction

  logic [DW-1:0] ram_rr [256];
  logic [DW-1:0] ram_pri[256];
  bit ram_ready = 1'b0;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) begin
        ram_rr[i]  = init_word(i[7:0]);
        ram_pri[i] = init_word(i[7:0]);
      end
      ram_ready = 1'b1;
    end else begin
      if (bus_rr.mem_we)  ram_rr[bus_rr.mem_addr[7:0]]   <= bus_rr.mem_wdata;
      if (bus_pri.mem_we) ram_pri[bus_pri.mem_addr[7:0]] <= bus_pri.mem_wdata;
    end
    bus_rr.mem_rdata  <= ram_rr[bus_rr.mem_addr[7:0]];
    bus_pri.mem_rdata <= ram_pri[bus_pri.mem_addr[7:0]];
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard entries are {dma_ack, rdata of the acked port}.
  logic [DW:0] exp_rr_q[$];
  logic [DW:0] exp_pri_q[$];

  function automatic logic [DW:0] exp_cpu(input logic [DW-1:0] d);
    return {REQ_CPU, d};
  endfunction
  function automatic logic [DW:0] exp_dma(input logic [DW-1:0] d);
    return {REQ_DMA, d};
  endfunction

  logic prev_ack_rr = 1'b0;
  logic prev_ack_pri = 1'b0;

  always @(negedge clk) begin
    logic [DW:0] e;
    if (reset === 1'b1 && (bus_rr.cpu_ack || bus_rr.dma_ack)) begin
      check("rr_ack_overlap", bus_rr.cpu_ack & bus_rr.dma_ack, 1'b0);
      check("rr_ack_back_to_back", prev_ack_rr, 1'b0);
      check("rr_ack_expected", exp_rr_q.size() != 0, 1'b1);
      if (exp_rr_q.size() != 0) begin
        e = exp_rr_q.pop_front();
        check("rr_ack_id_data",
              {bus_rr.dma_ack, bus_rr.dma_ack ? bus_rr.dma_rdata : bus_rr.cpu_rdata}, e);
      end
    end
    prev_ack_rr = bus_rr.cpu_ack | bus_rr.dma_ack;
  end

  always @(negedge clk) begin
    logic [DW:0] e;
    if (reset === 1'b1 && (bus_pri.cpu_ack || bus_pri.dma_ack)) begin
      check("pri_ack_overlap", bus_pri.cpu_ack & bus_pri.dma_ack, 1'b0);
      check("pri_ack_back_to_back", prev_ack_pri, 1'b0);
      check("pri_ack_expected", exp_pri_q.size() != 0, 1'b1);
      if (exp_pri_q.size() != 0) begin
        e = exp_pri_q.pop_front();
        check("pri_ack_id_data",
              {bus_pri.dma_ack, bus_pri.dma_ack ? bus_pri.dma_rdata : bus_pri.cpu_rdata}, e);
      end
    end
    prev_ack_pri = bus_pri.cpu_ack | bus_pri.dma_ack;
  end

  // ---------------- driver helpers ----------------
  task automatic wait_ack_rr(output bit ok, output int n);
    ok = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus_rr.cpu_ack || bus_rr.dma_ack) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic do_cpu(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [DW-1:0] exp_rd, input string tag);
    bit ok;
    int n;
    exp_rr_q.push_back(exp_cpu(exp_rd));
    exp_pri_q.push_back(exp_cpu(exp_rd));
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    wait_ack_rr(ok, n);
    check({tag, "_ack_seen"}, ok, 1'b1);
    check({tag, "_latency"}, n, 3);
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bit ok;
    int n;
    int ack_cnt;
    int last_idx;
    logic [DW-1:0] last_d;

    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_addr = '0;

    repeat (3) @(negedge clk);
    check("rst_cpu_ack",   bus_rr.cpu_ack,   1'b0);
    check("rst_dma_ack",   bus_rr.dma_ack,   1'b0);
    check("rst_mem_we",    bus_rr.mem_we,    1'b0);
    check("rst_mem_addr",  bus_rr.mem_addr,  16'h0000);
    check("rst_mem_wdata", bus_rr.mem_wdata, 16'h0000);
    check("rst_cpu_rdata", bus_rr.cpu_rdata, 16'h0000);
    check("rst_dma_rdata", bus_rr.dma_rdata, 16'h0000);
    check("rst_busy",      busy_rr,          1'b0);
    check("rst_state",     st_pri,           ST_IDLE);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // CPU read alone
    exp_rr_q.push_back(exp_cpu(16'h1234));
    exp_pri_q.push_back(exp_cpu(16'h1234));
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    @(negedge clk);
    check("rd_idle_busy", busy_rr, 1'b0);
    @(negedge clk);
    check("rd_issue_busy",  busy_rr,         1'b1);
    check("rd_issue_state", st_rr,           ST_ISSUE);
    check("rd_issue_addr",  bus_rr.mem_addr, 16'h0040);
    check("rd_issue_we",    bus_rr.mem_we,   1'b0);
    check("rd_issue_ack",   bus_rr.cpu_ack,  1'b0);
    @(negedge clk);
    check("rd_resp_ack",   bus_rr.cpu_ack,   1'b1);
    check("rd_resp_dack",  bus_rr.dma_ack,   1'b0);
    check("rd_resp_busy",  busy_rr,          1'b1);
    check("rd_resp_rdata", bus_rr.cpu_rdata, 16'h1234);
    cpu_req = 1'b0;
    @(negedge clk);
    check("rd_after_busy",  busy_rr,          1'b0);
    check("rd_after_ack",   bus_rr.cpu_ack,   1'b0);
    check("rd_after_rdata", bus_rr.cpu_rdata, 16'h1234);

    // CPU write; cpu_rdata must keep the previous read value
    exp_rr_q.push_back(exp_cpu(16'h1234));
    exp_pri_q.push_back(exp_cpu(16'h1234));
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
    @(negedge clk);
    @(negedge clk);
    check("wr_issue_we",    bus_rr.mem_we,    1'b1);
    check("wr_issue_addr",  bus_rr.mem_addr,  16'h0010);
    check("wr_issue_wdata", bus_rr.mem_wdata, 16'hBEEF);
    @(negedge clk);
    check("wr_resp_we",  bus_rr.mem_we,  1'b0);
    check("wr_resp_ack", bus_rr.cpu_ack, 1'b1);
    cpu_req = 1'b0;
    @(negedge clk);
    check("wr_after_we", bus_pri.mem_we, 1'b0);
    do_cpu(1'b0, 16'h0010, 16'h0000, 16'hBEEF, "wr_readback");

    // Back-to-back DMA with req held, address stepped at each ack
    for (int k = 0; k < 4; k++) begin
      exp_rr_q.push_back(exp_dma(init_word(8'(8'h20 + k))));
      exp_pri_q.push_back(exp_dma(init_word(8'(8'h20 + k))));
    end
    @(posedge clk); #1;
    dma_req = 1'b1; dma_addr = 16'h0020;
    wait_ack_rr(ok, n);
    check("dma_first_ack_seen", ok, 1'b1);
    check("dma_first_latency", n, 3);
    for (int k = 1; k < 4; k++) begin
      last_d   = init_word(8'(8'h20 + k - 1));
      dma_addr = 16'(16'h0020 + k);
      @(negedge clk);
      check("dma_hold_rdata_a", bus_rr.dma_rdata, last_d);
      check("dma_gap_ack",      bus_rr.dma_ack,   1'b0);
      @(negedge clk);
      check("dma_hold_rdata_b", bus_rr.dma_rdata, last_d);
      @(negedge clk);
      check("dma_stream_ack", bus_rr.dma_ack, 1'b1);
    end
    dma_req = 1'b0;
    @(negedge clk);
    check("dma_final_rdata", bus_pri.dma_rdata, init_word(8'h23));

    // Both requesting continuously: round-robin alternates, priority gives C,C,D
    for (int k = 0; k < 6; k++) begin
      exp_rr_q.push_back((k % 2 == 0) ? exp_cpu(16'h1234) : exp_dma(init_word(8'h30)));
      exp_pri_q.push_back((k % 3 == 2) ? exp_dma(init_word(8'h30)) : exp_cpu(16'h1234));
    end
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    dma_req = 1'b1; dma_addr = 16'h0030;
    ack_cnt = 0;
    last_idx = 0;
    for (int i = 1; i <= 30 && ack_cnt < 6; i++) begin
      @(negedge clk);
      if (bus_rr.cpu_ack || bus_rr.dma_ack) begin
        ack_cnt++;
        last_idx = i;
      end
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    check("tie_ack_count", ack_cnt, 6);
    check("tie_total_cycles", last_idx, 18);
    @(negedge clk);

    // Reset during ISSUE of a write
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0050; cpu_wdata = 16'hAAAA;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_we_before", bus_rr.mem_we, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_we_rr",  bus_rr.mem_we,  1'b0);
    check("rst_mid_we_pri", bus_pri.mem_we, 1'b0);
    check("rst_mid_busy",   busy_rr,        1'b0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_no_ack", bus_rr.cpu_ack | bus_pri.cpu_ack, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // First tie after reset goes to the CPU in both modes
    exp_rr_q.push_back(exp_cpu(16'h1234));
    exp_pri_q.push_back(exp_cpu(16'h1234));
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    dma_req = 1'b1; dma_addr = 16'h0030;
    wait_ack_rr(ok, n);
    check("post_rst_ack_seen", ok, 1'b1);
    check("post_rst_cpu_first", bus_rr.cpu_ack, 1'b1);
    check("post_rst_cpu_first_pri", bus_pri.cpu_ack, 1'b1);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    @(negedge clk);

    // The aborted write must not have reached the RAM
    do_cpu(1'b0, 16'h0050, 16'h0000, init_word(8'h50), "aborted_wr");

    repeat (3) @(negedge clk);
    check("rr_queue_drained",  exp_rr_q.size(),  0);
    check("pri_queue_drained", exp_pri_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous block RAM between two requesters:
  - the multicycle CPU controller/datapath (read/write, port "cpu");
  - a read-only display/DMA fetch engine (port "dma").
- Sits between the requesters and the RAM's address/data/write-enable pins.
- Serialises accesses with a small FSM.
- Arbitration is CPU-priority with a starvation guard for DMA, or pure round-robin, chosen by parameter.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- CPU_PRIORITY, 1: 1 = CPU wins ties unless DMA is starved; 0 = round-robin.
- MAX_WAIT, 8: tie-losing DMA cycles before DMA is forced to win the next tie (CPU_PRIORITY=1 only); range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_ack  out  1  one-cycle pulse: access complete.
- cpu_rdata  out  DW  read data; valid while cpu_ack=1, then held.
- dma_req  in  1  DMA read request; held until dma_ack.
- dma_addr  in  AW  DMA address.
- dma_ack  out  1  one-cycle completion pulse.
- dma_rdata  out  DW  read data; valid while dma_ack=1, then held.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DW  RAM read data, registered inside the RAM (1-cycle read latency).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE.
  - All outputs = 0: cpu_ack, dma_ack, mem_we, mem_addr, mem_wdata, cpu_rdata, dma_rdata, busy.
  - last_grant = DMA, so the CPU wins the first round-robin tie.
  - Starvation counter = 0.
  - Reset mid-access aborts the access. mem_we drops immediately, with no clock edge needed. No ack is issued.
- States:
  - IDLE: waits for requests and selects a winner.
  - ISSUE: drives the RAM with the latched request.
  - RESP: captures read data and pulses the ack.
- IDLE:
  - Neither request set: stay in IDLE.
  - Exactly one request set: grant that requester.
  - Both set, CPU_PRIORITY=0: grant the requester that is not last_grant.
  - Both set, CPU_PRIORITY=1: grant CPU unless starve_cnt ≥ MAX_WAIT, in which case grant DMA.
  - On a grant, latch the winner id, address, we (0 for DMA) and wdata. Next state = ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_addr and mem_wdata are driven from the latch.
  - mem_we = latched we.
  - Next state = RESP.
- RESP (exactly 1 cycle):
  - mem_we = 0.
  - On a read, mem_rdata is registered into the winner's rdata register.
  - Winner's ack = 1 for this single cycle.
  - last_grant is updated to the winner.
  - Next state = IDLE.
- Acks and read data:
  - Acks are registered and never high in two consecutive cycles.
  - cpu_ack and dma_ack are never high together.
  - Writes also pass through RESP. cpu_rdata is left unchanged on a write.
- Latency:
  - Request sampled in IDLE at edge N → ISSUE after N → RESP (ack high) after N+1.
  - That is 2 cycles from grant to ack, and 3 cycles per access including the return to IDLE.
  - Maximum throughput is one access per 3 cycles.
- Handshake:
  - The requester holds req, addr, we and wdata stable until it sees ack.
  - It deasserts req in the ack cycle or later.
  - If req is still high when the FSM is back in IDLE, it is treated as a new request. This is intended for back-to-back streaming.
  - Input changes while not in IDLE are ignored because the request is latched at grant.
- Starvation counter (8 bits, saturating):
  - Increments in IDLE when dma_req=1 and CPU is granted.
  - Clears when DMA is granted.
  - Holds otherwise.
- mem_addr and mem_wdata hold their last values in IDLE. Only mem_we is a timing-critical qualifier.

Decomposition:
- Shared package (ctrl_pkg, alongside the existing controller constants):
  - state encodings: IDLE=2'b00, ISSUE=2'b01, RESP=2'b10; 2'b11 is illegal and recovers to IDLE;
  - requester ids: REQ_CPU=1'b0, REQ_DMA=1'b1.
- One combinational sub-module, arb_pick:
  - inputs: cpu_req, dma_req, last_grant, starved, mode;
  - outputs: grant_valid, grant_id.
  - Isolating it allows the priority policy to be tested exhaustively.
- The FSM, latches and counter stay in mem_port_arbiter.

Test Plan:
- CPU read alone: mem holds 0x1234 at 0x0040; cpu_req=1, we=0, addr=0x0040 → cpu_ack high exactly 2 cycles after grant; cpu_rdata=0x1234; dma_ack stays 0; busy high for 2 cycles.
- CPU write: addr=0x0010, wdata=0xBEEF → mem_we=1 for exactly one cycle (ISSUE) with mem_addr=0x0010; a following read returns 0xBEEF; cpu_rdata unchanged by the write.
- Simultaneous requests, CPU_PRIORITY=0, both held for 4 accesses → grant order CPU, DMA, CPU, DMA; acks never overlap; 12 cycles total.
- Starvation, CPU_PRIORITY=1, MAX_WAIT=2: CPU and DMA requesting continuously → CPU, CPU, then DMA granted; counter then cleared and pattern repeats.
- Reset during ISSUE of a write → mem_we falls to 0 before the next clk edge; no ack; after release, the first tied request goes to CPU.
- Back-to-back DMA with dma_req held high → dma_ack pulses every 3 cycles with sequential rdata; dma_rdata stable between pulses.
